// File: rtl/apb_slave_pkg.sv
// rtl/apb_slave_pkg.sv - shared FSM states and sizing constants for the APB register slave
package apb_slave_pkg;

  // Transfer FSM: idle until a setup phase, then wait/complete in the access phase
  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_WAIT = 1'b1
  } state_t;

  // Byte distance between consecutive word registers
  localparam int REG_STRIDE = 4;
  // Width of the access-phase wait counter (supports 0..15 wait states)
  localparam int CNT_W = 4;

endpackage

// File: rtl/apb_slv_regbank.sv
// rtl/apb_slv_regbank.sv - word register storage, address decode, error detect and byte-lane writes
module apb_slv_regbank
  import apb_slave_pkg::*;
#(
  parameter int          ADDRWIDTH = 16,
  parameter int          NUM_REGS  = 8,
  parameter logic [31:0] ID_VALUE  = 32'hA5B0_0001
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic [ADDRWIDTH-1:0] addr_i,
  input  logic                 write_i,
  output logic [31:0]          rd_data_o,
  output logic                 err_o,
  input  logic                 we_i,
  input  logic [ADDRWIDTH-1:0] wr_addr_i,
  input  logic [31:0]          wr_data_i,
  input  logic [3:0]           wr_strb_i
);

  localparam int          ALIGN_BITS = $clog2(REG_STRIDE);
  localparam logic [31:0] ID_IDX     = 32'(NUM_REGS - 1);

  // The last index is the ID register, so only NUM_REGS-1 words need storage
  logic [31:0] regs_q [NUM_REGS-1];

  logic [31:0] rd_idx;
  logic [31:0] wr_idx;

  assign rd_idx = 32'(addr_i[ADDRWIDTH-1:ALIGN_BITS]);
  assign wr_idx = 32'(wr_addr_i[ADDRWIDTH-1:ALIGN_BITS]);

  // Decode the live address: read mux plus error classification for the setup phase
  always_comb begin
    rd_data_o = '0;
    for (int i = 0; i < NUM_REGS - 1; i++) begin
      if (rd_idx == 32'(i)) rd_data_o = regs_q[i];
    end
    if (rd_idx == ID_IDX) rd_data_o = ID_VALUE;
    err_o = (addr_i[ALIGN_BITS-1:0] != '0)
          || (rd_idx >= 32'(NUM_REGS))
          || (write_i && (rd_idx == ID_IDX));
    if (err_o) rd_data_o = '0;
  end

  // Commit a completed write into the enabled byte lanes of the addressed word
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < NUM_REGS - 1; i++) regs_q[i] <= '0;
    end else if (we_i) begin
      for (int i = 0; i < NUM_REGS - 1; i++) begin
        if (wr_idx == 32'(i)) begin
          for (int b = 0; b < 4; b++) begin
            if (wr_strb_i[b]) regs_q[i][8*b +: 8] <= wr_data_i[8*b +: 8];
          end
        end
      end
    end
  end

endmodule

// File: rtl/apb_reg_slave.sv
// rtl/apb_reg_slave.sv - APB3 completer with wait states and PSLVERR; APB4_STRB_EN adds PSTRB byte strobes
module apb_reg_slave
  import apb_slave_pkg::*;
#(
  parameter int          ADDRWIDTH   = 16,
  parameter int          DATAWIDTH   = 32,
  parameter int          NUM_REGS    = 8,
  parameter int          WAIT_STATES = 1,
  parameter logic [31:0] ID_VALUE    = 32'hA5B0_0001
) (
  input  logic                 HCLK,
  input  logic                 HRESETn,
  input  logic                 PCLKEN,
  input  logic                 PSEL,
  input  logic                 PENABLE,
  input  logic                 PWRITE,
  input  logic [ADDRWIDTH-1:0] PADDR,
  input  logic [DATAWIDTH-1:0] PWDATA,
`ifdef APB4_STRB_EN
  input  logic [3:0]           PSTRB,
`endif
  output logic                 PREADY,
  output logic [DATAWIDTH-1:0] PRDATA,
  output logic                 PSLVERR
);

  state_t                 state_q, state_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic [ADDRWIDTH-1:0]   addr_q, addr_d;
  logic                   wr_q, wr_d;
  logic [DATAWIDTH-1:0]   wdata_q, wdata_d;
  logic [3:0]             strb_q, strb_d;
  logic                   err_q, err_d;
  logic [DATAWIDTH-1:0]   rdata_q, rdata_d;
  logic [31:0]            bank_rdata;
  logic                   bank_err;
  logic                   commit;
  logic [3:0]             strb_in;

`ifdef APB4_STRB_EN
  assign strb_in = PSTRB;
`else
  assign strb_in = 4'hF;
`endif

  apb_slv_regbank #(
    .ADDRWIDTH (ADDRWIDTH),
    .NUM_REGS  (NUM_REGS),
    .ID_VALUE  (ID_VALUE)
  ) u_regbank (
    .clk_i     (HCLK),
    .rst_ni    (HRESETn),
    .addr_i    (PADDR),
    .write_i   (PWRITE),
    .rd_data_o (bank_rdata),
    .err_o     (bank_err),
    .we_i      (commit),
    .wr_addr_i (addr_q),
    .wr_data_i (wdata_q),
    .wr_strb_i (strb_q)
  );

  // Next-state and APB response: capture on setup, count wait states, complete or abort
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    addr_d  = addr_q;
    wr_d    = wr_q;
    wdata_d = wdata_q;
    strb_d  = strb_q;
    err_d   = err_q;
    rdata_d = rdata_q;
    commit  = 1'b0;
    PREADY  = 1'b0;
    PRDATA  = '0;
    PSLVERR = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (PCLKEN && PSEL && !PENABLE) begin
          state_d = ST_WAIT;
          cnt_d   = CNT_W'(WAIT_STATES);
          addr_d  = PADDR;
          wr_d    = PWRITE;
          wdata_d = PWDATA;
          strb_d  = strb_in;
          err_d   = bank_err;
          rdata_d = PWRITE ? '0 : bank_rdata;
        end
      end
      ST_WAIT: begin
        if (!PSEL) begin
          // Requester dropped the transfer: leave without writing
          if (PCLKEN) state_d = ST_IDLE;
        end else if (cnt_q != '0) begin
          if (PCLKEN) cnt_d = cnt_q - 1'b1;
        end else begin
          PREADY  = 1'b1;
          PRDATA  = rdata_q;
          PSLVERR = err_q;
          if (PENABLE && PCLKEN) begin
            commit  = wr_q && !err_q;
            state_d = ST_IDLE;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State, wait counter and setup-phase capture registers
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      addr_q  <= '0;
      wr_q    <= 1'b0;
      wdata_q <= '0;
      strb_q  <= '0;
      err_q   <= 1'b0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      wr_q    <= wr_d;
      wdata_q <= wdata_d;
      strb_q  <= strb_d;
      err_q   <= err_d;
      rdata_q <= rdata_d;
    end
  end

endmodule
